unidade_de_busca: RTL

Instruction-fetch controller that sequences the 8-bit instruction memory. It owns the program counter and drives the memory address each cycle. It registers the returned instruction into a one-entry instruction register with a valid/ready handshake toward the decoder. It also handles branch redirection, halt-opcode detection, out-of-range faults and a retired-instruction counter.

---
 rtl/unidade_de_busca.sv | 129 ++++++++++++
 1 files changed

// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction-fetch controller. Owns the PC, registers the fetched
// word into a one-entry instruction register, and handles branches, halt and range faults.
`default_nettype none

module unidade_de_busca #(
   parameter int                   ADDR_W      = 8,
   parameter int                   INSTR_W     = 8,
   parameter int                   MEM_DEPTH   = 52,
   parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_W-1:0]   HALT_OPCODE = '1
) (
   input  logic               clock,
   input  logic               reset,
   output logic [ADDR_W-1:0]  endereco,
   input  logic [INSTR_W-1:0] instrucao_mem,
   output logic [INSTR_W-1:0] instrucao,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               desvio,
   input  logic [ADDR_W-1:0]  alvo,
   output logic               halted,
   output logic               fault,
   output logic [15:0]        retired
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HALT  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH);

   state_t               state_q;
   logic [ADDR_W-1:0]    endereco_q;
   logic [INSTR_W-1:0]   instrucao_q;
   logic [ADDR_W-1:0]    instr_pc_q;
   logic                 instr_valid_q;
   logic                 halted_q;
   logic                 fault_q;
   logic [15:0]          retired_q;

   logic                 slot_free;
   logic                 transfer;
   logic                 out_of_range;

   assign slot_free    = !instr_valid_q || instr_ready;
   assign transfer     = instr_valid_q && instr_ready;
   assign out_of_range = ({1'b0, endereco_q} >= LIMIT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_BOOT;
         endereco_q    <= RESET_PC;
         instrucao_q   <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         retired_q     <= '0;
      end else begin
         if (transfer) begin
            retired_q <= retired_q + 16'd1;
         end

         case (state_q)
            S_BOOT: begin
               state_q <= S_FETCH;
            end

            S_FETCH: begin
               // A taken branch flushes the word being fetched this cycle.
               if (transfer && desvio) begin
                  endereco_q    <= alvo;
                  instr_valid_q <= 1'b0;
               end else if (slot_free) begin
                  if (out_of_range) begin
                     instr_valid_q <= 1'b0;
                     fault_q       <= 1'b1;
                     state_q       <= S_FAULT;
                  end else begin
                     instrucao_q   <= instrucao_mem;
                     instr_pc_q    <= endereco_q;
                     instr_valid_q <= 1'b1;
                     if (instrucao_mem == HALT_OPCODE) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                     end else begin
                        endereco_q <= endereco_q + ADDR_W'(1);
                     end
                  end
               end
            end

            S_HALT: begin
               if (transfer && desvio) begin
                  endereco_q    <= alvo;
                  instr_valid_q <= 1'b0;
                  halted_q      <= 1'b0;
                  state_q       <= S_FETCH;
               end else if (transfer) begin
                  instr_valid_q <= 1'b0;
               end
            end

            S_FAULT: begin
               instr_valid_q <= 1'b0;
            end

            default: begin
               state_q <= S_BOOT;
            end
         endcase
      end
   end

   assign endereco    = endereco_q;
   assign instrucao   = instrucao_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
   assign retired     = retired_q;

endmodule

`default_nettype wire
